// File: rtl/ctrl_seq_pkg.sv
// Shared types, IR field positions and opcode classification for the control sequencer.
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, DONE
  } state_t;

  typedef enum logic [1:0] {
    CLS_NONE, CLS_BIN, CLS_UN, CLS_MD
  } op_class_t;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RA_MSB = 26;
  localparam int RA_LSB = 23;
  localparam int RB_MSB = 22;
  localparam int RB_LSB = 19;
  localparam int RC_MSB = 18;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  function automatic op_class_t decode_class(input logic [4:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: cls = CLS_BIN;
      OP_NEG, OP_NOT:                  cls = CLS_UN;
      OP_MUL, OP_DIV:                  cls = CLS_MD;
      default:                         cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// Turns a 4-bit register index plus enable into a one-hot register select bus.
module reg_sel_decoder #(
  parameter int NREG = 16
) (
  input  logic [3:0]      idx,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en && (int'(idx) < NREG))
      onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired T0..T6 control sequencer for one ALU instruction on the bus datapath.
// Optional macro ILLEGAL_TRAP_EN: trap unsupported opcodes with a sticky illegal flag.
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int NREG = 16,
  parameter int OPW  = 5
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic            mem_ready,
  input  logic [31:0]     ir,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            pc_out,
  output logic            pc_increment,
  output logic            mar_in,
  output logic            pc_in,
  output logic            read,
  output logic            mdr_in,
  output logic            mdr_out,
  output logic            ir_in,
  output logic            y_in,
  output logic            zlow_in,
  output logic            zhigh_in,
  output logic            zlow_out,
  output logic            zhigh_out,
  output logic            hi_in,
  output logic            lo_in,
  output logic [OPW-1:0]  op_code,
  output logic [NREG-1:0] r_in,
  output logic [NREG-1:0] r_out
);

  state_t    state, next_state;
  op_class_t cls;

  logic [OPW-1:0] op;
  logic [3:0]     ra, rb, rc;
  logic [3:0]     ri_idx, ro_idx;
  logic           ri_en, ro_en;
  logic           unused_ir_bits;

  assign op  = ir[OP_LSB +: OPW];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign rc  = ir[RC_MSB:RC_LSB];
  assign cls = decode_class(op);
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!clr)
      state <= IDLE;
    else
      state <= next_state;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk) begin
    if (!clr)
      illegal_q <= 1'b0;
    else if (state == T3 && cls == CLS_NONE)
      illegal_q <= 1'b1;
  end

  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  // Unsupported opcodes leave T3 straight for DONE with no strobes in either build.
  always_comb begin
    next_state   = state;
    pc_out       = 1'b0;
    pc_increment = 1'b0;
    mar_in       = 1'b0;
    pc_in        = 1'b0;
    read         = 1'b0;
    mdr_in       = 1'b0;
    mdr_out      = 1'b0;
    ir_in        = 1'b0;
    y_in         = 1'b0;
    zlow_in      = 1'b0;
    zhigh_in     = 1'b0;
    zlow_out     = 1'b0;
    zhigh_out    = 1'b0;
    hi_in        = 1'b0;
    lo_in        = 1'b0;
    op_code      = '0;
    ri_en        = 1'b0;
    ri_idx       = '0;
    ro_en        = 1'b0;
    ro_idx       = '0;

    case (state)
      IDLE: if (start) next_state = T0;
      T0: begin
        pc_out       = 1'b1;
        pc_increment = 1'b1;
        mar_in       = 1'b1;
        zlow_in      = 1'b1;
        zhigh_in     = 1'b1;
        next_state   = T1;
      end
      T1: begin
        zlow_out = 1'b1;
        pc_in    = 1'b1;
        read     = 1'b1;
        mdr_in   = 1'b1;
        if (mem_ready) next_state = T2;
      end
      T2: begin
        mdr_out    = 1'b1;
        ir_in      = 1'b1;
        next_state = T3;
      end
      T3: begin
        case (cls)
          CLS_BIN: begin
            ro_en = 1'b1; ro_idx = rb; y_in = 1'b1;
            next_state = T4;
          end
          CLS_MD: begin
            ro_en = 1'b1; ro_idx = ra; y_in = 1'b1;
            next_state = T4;
          end
          CLS_UN: begin
            ro_en = 1'b1; ro_idx = rb; op_code = op;
            zlow_in = 1'b1; zhigh_in = 1'b1;
            next_state = T5;
          end
          default: next_state = DONE;
        endcase
      end
      T4: begin
        next_state = T5;
        case (cls)
          CLS_BIN: begin
            ro_en = 1'b1; ro_idx = rc; op_code = op;
            zlow_in = 1'b1; zhigh_in = 1'b1;
          end
          CLS_MD: begin
            ro_en = 1'b1; ro_idx = rb; op_code = op;
            zlow_in = 1'b1; zhigh_in = 1'b1;
          end
          default: next_state = DONE;
        endcase
      end
      T5: begin
        next_state = DONE;
        case (cls)
          CLS_BIN, CLS_UN: begin
            zlow_out = 1'b1; ri_en = 1'b1; ri_idx = ra;
          end
          CLS_MD: begin
            zlow_out = 1'b1; lo_in = 1'b1;
            next_state = T6;
          end
          default: ;
        endcase
      end
      T6: begin
        zhigh_out  = 1'b1;
        hi_in      = 1'b1;
        next_state = DONE;
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  reg_sel_decoder #(.NREG(NREG)) u_rin_dec (
    .idx    (ri_idx),
    .en     (ri_en),
    .onehot (r_in)
  );

  reg_sel_decoder #(.NREG(NREG)) u_rout_dec (
    .idx    (ro_idx),
    .en     (ro_en),
    .onehot (r_out)
  );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench: per-cycle compare against a microprogram-table model, plus directed literal checks.
module tb_ctrl_sequencer;

  typedef struct packed {
    logic busy, done, illegal;
    logic pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out, ir_in, y_in;
    logic zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
    logic [4:0]  op_code;
    logic [15:0] r_in;
    logic [15:0] r_out;
  } obs_t;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b1;
  logic [31:0] ir = 32'h0;

  logic busy, done, illegal, pc_out, pc_increment, mar_in, pc_in, read, mdr_in, mdr_out;
  logic ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in;
  logic [4:0]  op_code;
  logic [15:0] r_in, r_out;

  int passCount = 0;
  int checkCount = 0;
  bit cmpEn = 1'b0;

  obs_t dutObs;
  obs_t capv [0:13];

  logic [4:0] legalOps [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b10001,
                                5'b10010, 5'b01111, 5'b10000, 5'b00011};

  ctrl_sequencer #(.NREG(16), .OPW(5)) dut (
    .clk          (clk),
    .clr          (clr),
    .start        (start),
    .mem_ready    (mem_ready),
    .ir           (ir),
    .busy         (busy),
    .done         (done),
    .illegal      (illegal),
    .pc_out       (pc_out),
    .pc_increment (pc_increment),
    .mar_in       (mar_in),
    .pc_in        (pc_in),
    .read         (read),
    .mdr_in       (mdr_in),
    .mdr_out      (mdr_out),
    .ir_in        (ir_in),
    .y_in         (y_in),
    .zlow_in      (zlow_in),
    .zhigh_in     (zhigh_in),
    .zlow_out     (zlow_out),
    .zhigh_out    (zhigh_out),
    .hi_in        (hi_in),
    .lo_in        (lo_in),
    .op_code      (op_code),
    .r_in         (r_in),
    .r_out        (r_out)
  );

  always #5 clk = ~clk;

  assign dutObs = {busy, done, illegal, pc_out, pc_increment, mar_in, pc_in, read, mdr_in,
                   mdr_out, ir_in, y_in, zlow_in, zhigh_in, zlow_out, zhigh_out, hi_in, lo_in,
                   op_code, r_in, r_out};

  // Instruction class: 0 unsupported, 1 binary, 2 unary, 3 multiply/divide.
  function automatic int classOf(input logic [31:0] w);
    int c;
    if (w[31:27] inside {[5'd3:5'd11]}) c = 1;
    else if (w[31:27] inside {5'd17, 5'd18}) c = 2;
    else if (w[31:27] inside {5'd15, 5'd16}) c = 3;
    else c = 0;
    return c;
  endfunction

  // Microprogram length including the final done step.
  function automatic int progLen(input logic [31:0] w);
    int lens [4] = '{5, 7, 6, 8};
    return lens[classOf(w)];
  endfunction

  function automatic obs_t expectObs(input logic run, input int step, input logic [31:0] w,
                                     input logic ill);
    obs_t o;
    int   e;
    int   ra, rb, rc;
    o = '0;
    o.illegal = ill;
    ra = int'(w[26:23]);
    rb = int'(w[22:19]);
    rc = int'(w[18:15]);
    if (run) begin
      o.busy = 1'b1;
      e = step - 3;
      if (step == progLen(w) - 1) o.done = 1'b1;
      else if (step == 0) {o.pc_out, o.pc_increment, o.mar_in, o.zlow_in, o.zhigh_in} = '1;
      else if (step == 1) {o.zlow_out, o.pc_in, o.read, o.mdr_in} = '1;
      else if (step == 2) {o.mdr_out, o.ir_in} = '1;
      else begin
        case (classOf(w))
          1: case (e)
               0: begin o.r_out = 16'(1) << rb; o.y_in = 1'b1; end
               1: begin o.r_out = 16'(1) << rc; o.op_code = w[31:27]; {o.zlow_in, o.zhigh_in} = '1; end
               default: begin o.zlow_out = 1'b1; o.r_in = 16'(1) << ra; end
             endcase
          2: case (e)
               0: begin o.r_out = 16'(1) << rb; o.op_code = w[31:27]; {o.zlow_in, o.zhigh_in} = '1; end
               default: begin o.zlow_out = 1'b1; o.r_in = 16'(1) << ra; end
             endcase
          3: case (e)
               0: begin o.r_out = 16'(1) << ra; o.y_in = 1'b1; end
               1: begin o.r_out = 16'(1) << rb; o.op_code = w[31:27]; {o.zlow_in, o.zhigh_in} = '1; end
               2: begin o.zlow_out = 1'b1; o.lo_in = 1'b1; end
               default: begin o.zhigh_out = 1'b1; o.hi_in = 1'b1; end
             endcase
          default: ;
        endcase
      end
    end
    return o;
  endfunction

  // Model state: whether an instruction is in flight and which microprogram step it is on.
  logic mRun = 1'b0;
  int   mStep = 0;
  logic mIll = 1'b0;

  always @(posedge clk) begin
    if (!clr) begin
      mRun  <= 1'b0;
      mStep <= 0;
      mIll  <= 1'b0;
    end else if (!mRun) begin
      if (start) begin
        mRun  <= 1'b1;
        mStep <= 0;
      end
    end else if (mStep == progLen(ir) - 1) begin
      mRun <= 1'b0;
    end else if (!(mStep == 1 && !mem_ready)) begin
      mStep <= mStep + 1;
`ifdef ILLEGAL_TRAP_EN
      if (mStep == 3 && classOf(ir) == 0) mIll <= 1'b1;
`endif
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
    else
      passCount++;
  endtask

  always @(negedge clk) begin
    if (cmpEn)
      checkOutput($sformatf("cycle@%0t", $time), 64'(dutObs),
                  64'(expectObs(mRun, mStep, ir, mIll)));
  end

  // Issues one instruction and captures 14 cycles of outputs starting at T0.
  task automatic applyStimulus(input logic [31:0] instr, input int waits, input bit hold,
                               input int abortAt, output int lat);
    ir = instr;
    start = 1'b1;
    mem_ready = 1'b1;
    lat = -1;
    for (int j = 0; j < 14; j++) begin
      @(negedge clk);
      capv[j] = dutObs;
      if (lat < 0 && dutObs.done) lat = j;
      #1;
      if (!hold) start = 1'b0;
      mem_ready = !(j >= 1 && j <= waits);
      clr = (j == abortAt) ? 1'b0 : 1'b1;
    end
    start = 1'b0;
    mem_ready = 1'b1;
    clr = 1'b1;
    for (int k = 0; k < 30 && (mRun || busy); k++) begin
      @(negedge clk);
      #1;
    end
    if (mRun || busy) checkOutput("drain_timeout", 64'(busy), 64'(0));
  endtask

  function automatic logic [63:0] orRin(input int from);
    logic [63:0] acc = '0;
    for (int j = from; j < 14; j++) acc |= 64'(capv[j].r_in);
    return acc;
  endfunction

  function automatic logic [63:0] randIr();
    logic [4:0] op;
    int r = int'($urandom % 16);
    op = (r < 14) ? legalOps[r] : 5'($urandom);
    return {32'(op) << 27} | 64'($urandom & 32'h07FF_FFFF);
  endfunction

  initial begin
    int lat;
    int reads;
    repeat (2) @(negedge clk);
    #1;
    clr = 1'b1;
    cmpEn = 1'b1;
    checkOutput("reset_state", 64'(dutObs), 64'(0));

    applyStimulus(32'h521B8000, 0, 1'b0, -1, lat);
    checkOutput("shra_latency", 64'(lat), 64'(6));
    checkOutput("shra_t3_rout", 64'(capv[3].r_out), 64'h0008);
    checkOutput("shra_t4_rout", 64'(capv[4].r_out), 64'h0080);
    checkOutput("shra_t4_op", 64'(capv[4].op_code), 64'(5'b01010));
    checkOutput("shra_t5_rin", 64'(capv[5].r_in), 64'h0010);

    applyStimulus(32'h79280000, 0, 1'b0, -1, lat);
    checkOutput("mul_latency", 64'(lat), 64'(7));
    checkOutput("mul_t5_lo", 64'(capv[5].lo_in), 64'(1));
    checkOutput("mul_t6_hi", 64'(capv[6].hi_in), 64'(1));
    checkOutput("mul_no_rin", orRin(0), 64'(0));

    applyStimulus(32'h90880000, 0, 1'b0, -1, lat);
    checkOutput("not_latency", 64'(lat), 64'(5));
    checkOutput("not_t4_rin", 64'(capv[4].r_in), 64'h0002);

    applyStimulus(32'h521B8000, 3, 1'b0, -1, lat);
    reads = 0;
    for (int j = 0; j < 14; j++) reads += int'(capv[j].read);
    checkOutput("wait_latency", 64'(lat), 64'(9));
    checkOutput("wait_read_cycles", 64'(reads), 64'(4));

    applyStimulus(32'h521B8000, 0, 1'b0, 4, lat);
    checkOutput("abort_idle", 64'(capv[5]), 64'(0));
    checkOutput("abort_no_rin", orRin(4), 64'(0));
    checkOutput("abort_no_done", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);
    applyStimulus(32'h521B8000, 0, 1'b0, -1, lat);
    checkOutput("after_abort_latency", 64'(lat), 64'(6));

    applyStimulus(32'hF8000000, 0, 1'b0, -1, lat);
    checkOutput("illegal_latency", 64'(lat), 64'(4));
`ifdef ILLEGAL_TRAP_EN
    checkOutput("illegal_flag", 64'(capv[4].illegal), 64'(1));
`else
    checkOutput("illegal_flag", 64'(capv[4].illegal), 64'(0));
`endif
    checkOutput("illegal_no_rin", orRin(0), 64'(0));

    applyStimulus(32'h521B8000, 0, 1'b1, -1, lat);
    checkOutput("hold_done", 64'(capv[6].done), 64'(1));
    checkOutput("hold_idle_gap", 64'(capv[7].busy), 64'(0));
    checkOutput("hold_second_t0", 64'(capv[8].pc_out), 64'(1));

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      #1;
      if (!mRun) ir = randIr()[31:0];
      start = ($urandom % 3) == 0;
      mem_ready = ($urandom % 4) != 0;
      clr = ($urandom % 97) != 0;
    end
    clr = 1'b1;
    start = 1'b0;
    mem_ready = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    cmpEn = 1'b0;
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
